// File: rtl/axil_jtag_mailbox.sv
// AXI-lite slave mailbox between the CPU and the JTAG shift logic.
// Independent TX (CPU->host) and RX (host->CPU) circular FIFOs, a status
// register, an interrupt enable register and a maskable level interrupt.
module axil_jtag_mailbox #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 32
) (
   input  logic              sclk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] s_axi_awaddr_i,
   input  logic              s_axi_awvalid_i,
   output logic              s_axi_awready_o,
   input  logic [31:0]       s_axi_wdata_i,
   input  logic [3:0]        s_axi_wstrb_i,
   input  logic              s_axi_wvalid_i,
   output logic              s_axi_wready_o,
   output logic [1:0]        s_axi_bresp_o,
   output logic              s_axi_bvalid_o,
   input  logic              s_axi_bready_i,
   input  logic [ADDR_W-1:0] s_axi_araddr_i,
   input  logic              s_axi_arvalid_i,
   output logic              s_axi_arready_o,
   output logic [31:0]       s_axi_rdata_o,
   output logic [1:0]        s_axi_rresp_o,
   output logic              s_axi_rvalid_o,
   input  logic              s_axi_rready_i,
   output logic [DATA_W-1:0] h_tx_data,
   output logic              h_tx_valid,
   input  logic              h_tx_ready,
   input  logic [DATA_W-1:0] h_rx_data,
   input  logic              h_rx_valid,
   output logic              h_rx_ready,
   output logic              INT
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t          w_state_q, w_state_d;
   r_state_t          r_state_q, r_state_d;
   logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [DATA_W-1:0] tx_mem_q [DEPTH];
   logic [DATA_W-1:0] rx_mem_q [DEPTH];
   logic [PTR_W-1:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [PTR_W-1:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [2:0]        int_en_q, int_en_d;
   logic              ovf_q, ovf_d, int_q, int_d;
   logic              tx_full, tx_empty, rx_full, rx_empty;
   logic              tx_push, tx_pop, rx_push, rx_pop, ovf_clr;
   logic              wr_addr_ok, rd_addr_ok;
   logic [2:0]        int_stat;
   logic [31:0]       status;
   logic              unused_addr_bits;

   assign tx_full    = (tx_cnt_q == CNT_W'(DEPTH));
   assign tx_empty   = (tx_cnt_q == '0);
   assign rx_full    = (rx_cnt_q == CNT_W'(DEPTH));
   assign rx_empty   = (rx_cnt_q == '0);
   assign wr_addr_ok = (s_axi_awaddr_i[ADDR_W-1:4] == '0);
   assign rd_addr_ok = (s_axi_araddr_i[ADDR_W-1:4] == '0);
   assign int_stat   = {ovf_q, tx_empty, !rx_empty};
   assign status     = {8'h00, 8'(rx_cnt_q), 8'(tx_cnt_q), 4'h0,
                        rx_empty, rx_full, tx_empty, tx_full};
   assign unused_addr_bits = ^{s_axi_awaddr_i[1:0], s_axi_araddr_i[1:0]};

   assign s_axi_wready_o = s_axi_awready_o;
   assign s_axi_bvalid_o = (w_state_q == W_RESP);
   assign s_axi_bresp_o  = bresp_q;
   assign s_axi_rvalid_o = (r_state_q == R_DATA);
   assign s_axi_rresp_o  = rresp_q;
   assign s_axi_rdata_o  = rdata_q;
   assign h_tx_valid     = !tx_empty;
   assign h_tx_data      = tx_mem_q[tx_rd_q];
   assign h_rx_ready     = !rx_full;
   assign INT            = int_q;

   // Write channel: accept address and data together, perform the register action at the handshake.
   always_comb begin
      w_state_d       = w_state_q;
      bresp_d         = bresp_q;
      int_en_d        = int_en_q;
      tx_push         = 1'b0;
      ovf_clr         = 1'b0;
      s_axi_awready_o = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (reset && s_axi_awvalid_i && s_axi_wvalid_i) begin
               s_axi_awready_o = 1'b1;
               w_state_d       = W_RESP;
               bresp_d         = RESP_SLVERR;
               if (wr_addr_ok) begin
                  case (s_axi_awaddr_i[3:2])
                     2'd0: if (s_axi_wstrb_i == 4'hF && !tx_full) begin
                        tx_push = 1'b1;
                        bresp_d = RESP_OKAY;
                     end
                     2'd2: if (s_axi_wstrb_i[0]) begin
                        int_en_d = s_axi_wdata_i[2:0];
                        bresp_d  = RESP_OKAY;
                     end
                     2'd3: begin
                        ovf_clr = s_axi_wdata_i[2];
                        bresp_d = RESP_OKAY;
                     end
                     default: ;
                  endcase
               end
            end
         end
         default: if (s_axi_bready_i) w_state_d = W_IDLE;
      endcase
   end

   // Read channel: register the response and pop RX at the address handshake.
   always_comb begin
      r_state_d       = r_state_q;
      rresp_d         = rresp_q;
      rdata_d         = rdata_q;
      rx_pop          = 1'b0;
      s_axi_arready_o = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            s_axi_arready_o = reset;
            if (reset && s_axi_arvalid_i) begin
               r_state_d = R_DATA;
               rresp_d   = RESP_SLVERR;
               rdata_d   = '0;
               if (rd_addr_ok) begin
                  case (s_axi_araddr_i[3:2])
                     2'd0: if (!rx_empty) begin
                        rx_pop  = 1'b1;
                        rdata_d = 32'(rx_mem_q[rx_rd_q]);
                        rresp_d = RESP_OKAY;
                     end
                     2'd1: begin
                        rdata_d = status;
                        rresp_d = RESP_OKAY;
                     end
                     2'd2: begin
                        rdata_d = {29'd0, int_en_q};
                        rresp_d = RESP_OKAY;
                     end
                     default: begin
                        rdata_d = {29'd0, int_stat};
                        rresp_d = RESP_OKAY;
                     end
                  endcase
               end
            end
         end
         default: if (s_axi_rready_i) r_state_d = R_IDLE;
      endcase
   end

   // FIFO pointers/counts, sticky overflow (set beats clear) and the registered interrupt.
   always_comb begin
      tx_pop   = !tx_empty && h_tx_ready;
      rx_push  = h_rx_valid && !rx_full;
      tx_wr_d  = tx_push ? tx_wr_q + 1'b1 : tx_wr_q;
      tx_rd_d  = tx_pop  ? tx_rd_q + 1'b1 : tx_rd_q;
      rx_wr_d  = rx_push ? rx_wr_q + 1'b1 : rx_wr_q;
      rx_rd_d  = rx_pop  ? rx_rd_q + 1'b1 : rx_rd_q;
      tx_cnt_d = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
      rx_cnt_d = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
      ovf_d    = (ovf_q && !ovf_clr) || (h_rx_valid && rx_full);
      int_d    = |(int_stat & int_en_q);
   end

   // FIFO storage; contents are meaningless outside the count, so no reset.
   always_ff @(posedge sclk) begin
      if (tx_push) tx_mem_q[tx_wr_q] <= s_axi_wdata_i[DATA_W-1:0];
      if (rx_push) rx_mem_q[rx_wr_q] <= h_rx_data;
   end

   // Control state registers.
   always_ff @(posedge sclk or negedge reset) begin
      if (!reset) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         bresp_q   <= '0;
         rresp_q   <= '0;
         rdata_q   <= '0;
         tx_wr_q   <= '0;
         tx_rd_q   <= '0;
         rx_wr_q   <= '0;
         rx_rd_q   <= '0;
         tx_cnt_q  <= '0;
         rx_cnt_q  <= '0;
         int_en_q  <= '0;
         ovf_q     <= 1'b0;
         int_q     <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         bresp_q   <= bresp_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         tx_wr_q   <= tx_wr_d;
         tx_rd_q   <= tx_rd_d;
         rx_wr_q   <= rx_wr_d;
         rx_rd_q   <= rx_rd_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_cnt_q  <= rx_cnt_d;
         int_en_q  <= int_en_d;
         ovf_q     <= ovf_d;
         int_q     <= int_d;
      end
   end
endmodule

// File: tb/tb_axil_jtag_mailbox.sv
// Bench for axil_jtag_mailbox: queue-based reference model compared every
// cycle, plus directed sequences with literal expectations.
module tb_axil_jtag_mailbox;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 32;

   logic              sclk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] s_axi_awaddr_i, s_axi_araddr_i;
   logic              s_axi_awvalid_i, s_axi_awready_o;
   logic [31:0]       s_axi_wdata_i;
   logic [3:0]        s_axi_wstrb_i;
   logic              s_axi_wvalid_i, s_axi_wready_o;
   logic [1:0]        s_axi_bresp_o, s_axi_rresp_o;
   logic              s_axi_bvalid_o, s_axi_bready_i;
   logic              s_axi_arvalid_i, s_axi_arready_o;
   logic [31:0]       s_axi_rdata_o;
   logic              s_axi_rvalid_o, s_axi_rready_i;
   logic [DATA_W-1:0] h_tx_data, h_rx_data;
   logic              h_tx_valid, h_tx_ready, h_rx_valid, h_rx_ready;
   logic              INT;

   int checks = 0;
   int failures = 0;

   axil_jtag_mailbox #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .sclk(sclk), .reset(reset),
      .s_axi_awaddr_i(s_axi_awaddr_i), .s_axi_awvalid_i(s_axi_awvalid_i), .s_axi_awready_o(s_axi_awready_o),
      .s_axi_wdata_i(s_axi_wdata_i), .s_axi_wstrb_i(s_axi_wstrb_i), .s_axi_wvalid_i(s_axi_wvalid_i),
      .s_axi_wready_o(s_axi_wready_o),
      .s_axi_bresp_o(s_axi_bresp_o), .s_axi_bvalid_o(s_axi_bvalid_o), .s_axi_bready_i(s_axi_bready_i),
      .s_axi_araddr_i(s_axi_araddr_i), .s_axi_arvalid_i(s_axi_arvalid_i), .s_axi_arready_o(s_axi_arready_o),
      .s_axi_rdata_o(s_axi_rdata_o), .s_axi_rresp_o(s_axi_rresp_o), .s_axi_rvalid_o(s_axi_rvalid_o),
      .s_axi_rready_i(s_axi_rready_i),
      .h_tx_data(h_tx_data), .h_tx_valid(h_tx_valid), .h_tx_ready(h_tx_ready),
      .h_rx_data(h_rx_data), .h_rx_valid(h_rx_valid), .h_rx_ready(h_rx_ready),
      .INT(INT)
   );

   always #5 sclk = ~sclk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h @%0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] m_txq[$];
   logic [31:0] m_rxq[$];
   bit          m_wbusy, m_rbusy, m_ovf, m_int;
   logic [1:0]  m_bresp, m_rresp;
   logic [31:0] m_rdata;
   logic [2:0]  m_en;
   int          txn, rxn;
   bit          t_pop, t_push, r_pop, r_push, o_set, o_clr, n_int;

   always @(posedge sclk or negedge reset) begin
      if (!reset) begin
         m_txq.delete(); m_rxq.delete();
         m_wbusy = 0; m_rbusy = 0; m_ovf = 0; m_int = 0;
         m_bresp = 0; m_rresp = 0; m_rdata = 0; m_en = 0;
      end else begin
         txn    = m_txq.size();
         rxn    = m_rxq.size();
         n_int  = |({m_ovf, txn == 0, rxn != 0} & m_en);
         t_pop  = (txn != 0) && h_tx_ready;
         r_push = h_rx_valid && (rxn < DEPTH);
         o_set  = h_rx_valid && (rxn == DEPTH);
         t_push = 0; r_pop = 0; o_clr = 0;
         if (!m_wbusy) begin
            if (s_axi_awvalid_i && s_axi_wvalid_i) begin
               m_wbusy = 1; m_bresp = 2'b10;
               if (s_axi_awaddr_i < 32'h10) begin
                  if (s_axi_awaddr_i[3:2] == 2'd0 && s_axi_wstrb_i == 4'hF && txn < DEPTH) begin
                     t_push = 1; m_bresp = 0;
                  end else if (s_axi_awaddr_i[3:2] == 2'd2 && s_axi_wstrb_i[0]) begin
                     m_en = s_axi_wdata_i[2:0]; m_bresp = 0;
                  end else if (s_axi_awaddr_i[3:2] == 2'd3) begin
                     o_clr = s_axi_wdata_i[2]; m_bresp = 0;
                  end
               end
            end
         end else if (s_axi_bready_i) m_wbusy = 0;
         if (!m_rbusy) begin
            if (s_axi_arvalid_i) begin
               m_rbusy = 1; m_rresp = 2'b10; m_rdata = 0;
               if (s_axi_araddr_i < 32'h10) begin
                  case (s_axi_araddr_i[3:2])
                     2'd0: if (rxn != 0) begin m_rdata = m_rxq[0]; m_rresp = 0; r_pop = 1; end
                     2'd1: begin
                        m_rdata = rxn * 65536 + txn * 256 + (rxn == 0) * 8 + (rxn == DEPTH) * 4
                                  + (txn == 0) * 2 + (txn == DEPTH);
                        m_rresp = 0;
                     end
                     2'd2: begin m_rdata = 32'(m_en); m_rresp = 0; end
                     default: begin
                        m_rdata = m_ovf * 4 + (txn == 0) * 2 + (rxn != 0);
                        m_rresp = 0;
                     end
                  endcase
               end
            end
         end else if (s_axi_rready_i) m_rbusy = 0;
         if (t_pop)  void'(m_txq.pop_front());
         if (t_push) m_txq.push_back(s_axi_wdata_i);
         if (r_pop)  void'(m_rxq.pop_front());
         if (r_push) m_rxq.push_back(h_rx_data);
         m_ovf = o_set || (m_ovf && !o_clr);
         m_int = n_int;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge sclk) begin
      if (reset) begin
         chk("awready", 32'(s_axi_awready_o), 32'(!m_wbusy && s_axi_awvalid_i && s_axi_wvalid_i));
         chk("wready", 32'(s_axi_wready_o), 32'(!m_wbusy && s_axi_awvalid_i && s_axi_wvalid_i));
         chk("bvalid", 32'(s_axi_bvalid_o), 32'(m_wbusy));
         chk("bresp", 32'(s_axi_bresp_o), 32'(m_bresp));
         chk("arready", 32'(s_axi_arready_o), 32'(!m_rbusy));
         chk("rvalid", 32'(s_axi_rvalid_o), 32'(m_rbusy));
         chk("rresp", 32'(s_axi_rresp_o), 32'(m_rresp));
         chk("rdata", s_axi_rdata_o, m_rdata);
         chk("h_tx_valid", 32'(h_tx_valid), 32'(m_txq.size() != 0));
         if (m_txq.size() != 0) chk("h_tx_data", h_tx_data, m_txq[0]);
         chk("h_rx_ready", 32'(h_rx_ready), 32'(m_rxq.size() < DEPTH));
         chk("INT", 32'(INT), 32'(m_int));
      end
   end

   // ---------------- stimulus ----------------
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int n = 0;
      s_axi_awaddr_i = a; s_axi_wdata_i = d; s_axi_wstrb_i = s;
      s_axi_awvalid_i = 1; s_axi_wvalid_i = 1;
      do begin @(negedge sclk); n++; end while (!s_axi_awready_o && n < 20);
      chk("aw_handshake", 32'(s_axi_awready_o), 32'd1);
      @(posedge sclk); #1;
      s_axi_awvalid_i = 0; s_axi_wvalid_i = 0;
      chk("bvalid_after_hs", 32'(s_axi_bvalid_o), 32'd1);
      resp = s_axi_bresp_o;
      @(posedge sclk); #1;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n = 0;
      s_axi_araddr_i = a; s_axi_arvalid_i = 1;
      do begin @(negedge sclk); n++; end while (!s_axi_arready_o && n < 20);
      chk("ar_handshake", 32'(s_axi_arready_o), 32'd1);
      @(posedge sclk); #1;
      s_axi_arvalid_i = 0;
      chk("rvalid_after_hs", 32'(s_axi_rvalid_o), 32'd1);
      d = s_axi_rdata_o; resp = s_axi_rresp_o;
      @(posedge sclk); #1;
   endtask

   task automatic host_pop();
      h_tx_ready = 1; @(posedge sclk); #1; h_tx_ready = 0;
   endtask

   logic [1:0]  resp;
   logic [31:0] rd;

   initial begin
      reset = 0;
      s_axi_awaddr_i = 0; s_axi_araddr_i = 0; s_axi_wdata_i = 0; s_axi_wstrb_i = 0;
      s_axi_awvalid_i = 1; s_axi_wvalid_i = 1; s_axi_arvalid_i = 1;
      s_axi_bready_i = 1; s_axi_rready_i = 1;
      h_tx_ready = 0; h_rx_valid = 0; h_rx_data = 0;
      repeat (3) @(posedge sclk);
      #1;
      chk("rst_awready", 32'(s_axi_awready_o), 32'd0);
      chk("rst_arready", 32'(s_axi_arready_o), 32'd0);
      chk("rst_h_rx_ready", 32'(h_rx_ready), 32'd1);
      s_axi_awvalid_i = 0; s_axi_wvalid_i = 0; s_axi_arvalid_i = 0;
      @(posedge sclk); #1;
      reset = 1;
      @(posedge sclk); #1;
      chk("rst_INT", 32'(INT), 32'd0);
      chk("rst_h_tx_valid", 32'(h_tx_valid), 32'd0);
      chk("rst_bvalid", 32'(s_axi_bvalid_o), 32'd0);
      axi_read(32'h4, rd, resp);
      chk("rst_status", rd, 32'h0000_000A);

      // Ordered TX transfer.
      axi_write(32'h0, 32'h11, 4'hF, resp); chk("wr11_resp", 32'(resp), 32'd0);
      axi_write(32'h0, 32'h22, 4'hF, resp); chk("wr22_resp", 32'(resp), 32'd0);
      axi_write(32'h0, 32'h33, 4'hF, resp); chk("wr33_resp", 32'(resp), 32'd0);
      chk("tx_head0", h_tx_data, 32'h11); host_pop();
      chk("tx_head1", h_tx_data, 32'h22); host_pop();
      chk("tx_head2", h_tx_data, 32'h33); host_pop();
      axi_read(32'h4, rd, resp);
      chk("tx_drained_status", rd, 32'h0000_000A);

      // TX full boundary.
      for (int i = 0; i < 16; i++) begin
         axi_write(32'h0, 32'h100 + i, 4'hF, resp);
         chk("fill_resp", 32'(resp), 32'd0);
      end
      axi_write(32'h0, 32'hDEAD, 4'hF, resp);
      chk("wr17_slverr", 32'(resp), 32'd2);
      axi_read(32'h4, rd, resp);
      chk("tx_full_status", rd, 32'h0000_1009);
      chk("tx_full_head", h_tx_data, 32'h100);
      host_pop();
      axi_write(32'h0, 32'hAA, 4'hF, resp);
      chk("wr_after_pop", 32'(resp), 32'd0);
      h_tx_ready = 1;
      repeat (16) @(posedge sclk);
      #1; h_tx_ready = 0;
      chk("tx_empty_after_drain", 32'(h_tx_valid), 32'd0);

      // RX fill, overflow and interrupt.
      h_rx_valid = 1;
      for (int k = 0; k < 17; k++) begin
         h_rx_data = 32'h200 + k;
         @(posedge sclk); #1;
      end
      h_rx_valid = 0;
      chk("rx_full_ready", 32'(h_rx_ready), 32'd0);
      axi_read(32'h4, rd, resp);
      chk("rx_full_status", rd, 32'h0010_0006);
      axi_read(32'hC, rd, resp);
      chk("int_stat_ovf", rd, 32'h7);
      chk("int_masked", 32'(INT), 32'd0);
      axi_write(32'h8, 32'h4, 4'hF, resp);
      chk("int_en_resp", 32'(resp), 32'd0);
      chk("int_on", 32'(INT), 32'd1);
      axi_write(32'hC, 32'h4, 4'hF, resp);
      chk("w1c_resp", 32'(resp), 32'd0);
      chk("int_off", 32'(INT), 32'd0);

      // RX drain in order, then error cases.
      for (int k = 0; k < 16; k++) begin
         axi_read(32'h0, rd, resp);
         chk("rx_word", rd, 32'h200 + k);
      end
      axi_read(32'h0, rd, resp);
      chk("rx_empty_rdata", rd, 32'd0);
      chk("rx_empty_rresp", 32'(resp), 32'd2);
      axi_write(32'h10, 32'h5, 4'hF, resp);
      chk("bad_addr_wr", 32'(resp), 32'd2);
      axi_read(32'h10, rd, resp);
      chk("bad_addr_rd", 32'(resp), 32'd2);
      axi_write(32'h0, 32'h77, 4'h3, resp);
      chk("partial_strb", 32'(resp), 32'd2);
      axi_write(32'h4, 32'h1, 4'hF, resp);
      chk("status_wr", 32'(resp), 32'd2);
      axi_write(32'h8, 32'h7, 4'h2, resp);
      chk("int_en_nostrb", 32'(resp), 32'd2);
      axi_read(32'h4, rd, resp);
      chk("no_side_effect_status", rd, 32'h0000_000A);

      // Reset mid-transaction with both FIFOs holding data.
      for (int i = 0; i < 5; i++) axi_write(32'h0, 32'h300 + i, 4'hF, resp);
      h_rx_valid = 1;
      repeat (5) @(posedge sclk);
      #1; h_rx_valid = 0;
      s_axi_bready_i = 0;
      axi_write(32'h0, 32'h400, 4'hF, resp);
      chk("bvalid_pending", 32'(s_axi_bvalid_o), 32'd1);
      #2 reset = 0;
      #1 chk("bvalid_async_drop", 32'(s_axi_bvalid_o), 32'd0);
      chk("h_tx_valid_in_rst", 32'(h_tx_valid), 32'd0);
      @(posedge sclk); @(posedge sclk); #1;
      reset = 1; s_axi_bready_i = 1;
      @(posedge sclk); #1;
      axi_read(32'h4, rd, resp);
      chk("post_reset_status", rd, 32'h0000_000A);

      @(posedge sclk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
